// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and the renderer pixel type.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [11:0] pixel_t;

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with synchronous active-low clear to RST_VAL.
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int                WIDTH   = 1,
    parameter int                DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = DEPTH - 1; i > 0; i--)
            stage[i] <= clrn ? stage[i-1] : RST_VAL;
        stage[0] <= clrn ? d : RST_VAL;
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: VGA scan counters, pixel-request addressing and latency-matched sync/RGB outputs.
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int PIPE     = 2
) (
    input  logic       vga_clk,
    input  logic       clrn,
    input  pixel_t     d_in,
    output logic [9:0] col_addr,
    output logic [8:0] row_addr,
    output logic       rdn,
    output logic       frame_start,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       hs,
    output logic       vs
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic [9:0] h_count, v_count, h_next, v_next;
    logic       run, act_next, hs_raw, vs_raw;
    logic [2:0] dl_q;
    pixel_t     rgb;

    // The first enabled edge after reset holds the counters at 0,0 so frame_start fires in that cycle.
    always_comb begin
        h_next   = (!run || h_count == 10'(H_TOTAL - 1)) ? 10'd0 : h_count + 10'd1;
        v_next   = !run ? 10'd0 :
                   h_count != 10'(H_TOTAL - 1) ? v_count :
                   v_count == 10'(V_TOTAL - 1) ? 10'd0 : v_count + 10'd1;
        act_next = h_next < 10'(H_ACTIVE) && v_next < 10'(V_ACTIVE);
    end

    always_ff @(posedge vga_clk) begin
        if (!clrn) begin
            h_count     <= '0;
            v_count     <= '0;
            run         <= 1'b0;
            col_addr    <= '0;
            row_addr    <= '0;
            rdn         <= 1'b1;
            frame_start <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            rgb         <= '0;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            run         <= 1'b1;
            col_addr    <= act_next ? h_next : 10'd0;
            row_addr    <= act_next ? v_next[8:0] : 9'd0;
            rdn         <= !act_next;
            frame_start <= h_next == 10'd0 && v_next == 10'd0;
            hs_raw      <= !(h_next >= 10'(H_SYNC_START) && h_next < 10'(H_SYNC_END));
            vs_raw      <= !(v_next >= 10'(V_SYNC_START) && v_next < 10'(V_SYNC_END));
            rgb         <= dl_q[0] ? d_in : '0;
        end
    end

    // Active enters one cycle early (act_next) so its delayed copy gates the RGB register on the sampling edge.
    sync_delay_line #(
        .WIDTH  (3),
        .DEPTH  (PIPE),
        .RST_VAL(3'b110)
    ) u_sync_delay (
        .clk (vga_clk),
        .clrn(clrn),
        .d   ({hs_raw, vs_raw, act_next}),
        .q   (dl_q)
    );

    assign {hs, vs}  = dl_q[2:1];
    assign {r, g, b} = rgb;

endmodule
